// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Polarity is applied per pin so any matrix width can reuse the same helper.
package led_matrix_pkg;

    typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;

    function automatic logic apply_pol(input logic bits, input logic act_low);
        return act_low ? ~bits : bits;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Row-slot counter: counts 0..ROW_CYCLES-1 and flags the slot end and the drive window.
module scan_tick_gen #(
    parameter int ROW_CYCLES   = 27000,
    parameter int BLANK_CYCLES = 270,
    localparam int CNT_W       = $clog2(ROW_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             slot_wrap,
    output logic             drive_en
);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_SIZE = CNT_W'(BLANK_CYCLES);

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign drive_en  = (slot_cnt >= BLANK_SIZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_cnt <= '0;
        else if (slot_wrap)
            slot_cnt <= '0;
        else
            slot_cnt <= slot_cnt + 1'b1;
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered framebuffer.
// Buffers swap only on the last-row wrap, so a frame is never shown half old, half new.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int ROW_CYCLES    = 27000,
    parameter int BLANK_CYCLES  = 270,
    parameter int ANODE_ACT_LOW = 1,
    parameter int CATH_ACT_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [ROWS-1:0]         anode,
    output logic [COLS-1:0]         cathode
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROW_CYCLES);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic             AN_LOW     = (ANODE_ACT_LOW != 0);
    localparam logic             CA_LOW     = (CATH_ACT_LOW != 0);
    localparam logic [ROWS-1:0]  ANODE_OFF  = {ROWS{AN_LOW}};
    localparam logic [COLS-1:0]  CATH_OFF   = {COLS{CA_LOW}};

    if (BLANK_CYCLES >= ROW_CYCLES || BLANK_CYCLES < 1 || ROWS < 2) begin : g_param_err
        $error("led_matrix_scanner: need ROWS>=2 and 1<=BLANK_CYCLES<ROW_CYCLES");
    end

    logic [CNT_W-1:0] slot_cnt;
    logic             slot_wrap;
    logic             drive_en;

    scan_tick_gen #(
        .ROW_CYCLES  (ROW_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .slot_cnt (slot_cnt),
        .slot_wrap(slot_wrap),
        .drive_en (drive_en)
    );

    scan_state_t      state, state_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic             front_sel;
    logic             swap_pend;
    logic             swap_do;
    logic [COLS-1:0]  fb [2][ROWS];
    logic [ROWS-1:0]  anode_d;
    logic [COLS-1:0]  cathode_d;

    assign swap_do = slot_wrap && (row == ROW_LAST) && (swap_pend || swap_req);

    // Leaving DRIVE without drive_en only happens if state and counter disagree; it resyncs.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        case (state)
            S_BLANK: if (slot_cnt == BLANK_LAST) state_nxt = S_DRIVE;
            S_DRIVE: if (slot_wrap || !drive_en) state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
        if (slot_wrap)
            row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
    end

    always_comb begin
        anode_d   = ANODE_OFF;
        cathode_d = CATH_OFF;
        if (state == S_DRIVE) begin
            for (int i = 0; i < ROWS; i++)
                anode_d[i] = apply_pol(row == ROW_W'(i), AN_LOW);
            for (int j = 0; j < COLS; j++)
                cathode_d[j] = apply_pol(fb[front_sel][row][j], CA_LOW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_BLANK;
            row       <= '0;
            front_sel <= 1'b0;
            swap_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            front_sel <= front_sel ^ swap_do;
            swap_pend <= swap_do ? 1'b0 : (swap_pend | swap_req);
        end
    end

    // Writes always target the back buffer as seen before any swap on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                fb[0][r] <= '0;
                fb[1][r] <= '0;
            end
        end else if (wr_en && (int'(wr_row) < ROWS)) begin
            fb[~front_sel][wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode       <= ANODE_OFF;
            cathode     <= CATH_OFF;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            anode       <= anode_d;
            cathode     <= cathode_d;
            frame_start <= (slot_cnt == '0) && (row == '0);
            swap_ack    <= swap_do;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: an 8-row and a 6-row build share one stimulus stream
// and are checked every cycle against a time-indexed scan model.
module tb_led_matrix_scanner;

    localparam int RC = 10;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       swap_req = 1'b0;

    logic       ack8, fs8, ack6, fs6;
    logic [7:0] an8, ca8, ca6;
    logic [5:0] an6;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .ROWS(8), .COLS(8), .ROW_CYCLES(RC), .BLANK_CYCLES(BL),
        .ANODE_ACT_LOW(1), .CATH_ACT_LOW(0)
    ) u_dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(ack8), .frame_start(fs8),
        .anode(an8), .cathode(ca8)
    );

    led_matrix_scanner #(
        .ROWS(6), .COLS(8), .ROW_CYCLES(RC), .BLANK_CYCLES(BL),
        .ANODE_ACT_LOW(1), .CATH_ACT_LOW(0)
    ) u_dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(ack6), .frame_start(fs6),
        .anode(an6), .cathode(ca6)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: n = clock edges since reset release; scan position follows by plain arithmetic.
    logic [7:0] mbuf [2][2][8];
    int         mfront [2];
    bit         mpend [2];
    logic [7:0] e_an [2];
    logic [7:0] e_ca [2];
    logic       e_fs [2];
    logic       e_ack [2];
    int         n = 0;

    task automatic model_clear(input int k, input int rows);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) mbuf[k][b][r] = 8'h00;
        mfront[k] = 0;
        mpend[k]  = 1'b0;
        e_an[k]   = 8'((1 << rows) - 1);
        e_ca[k]   = 8'h00;
        e_fs[k]   = 1'b0;
        e_ack[k]  = 1'b0;
    endtask

    task automatic model_step(input int k, input int rows);
        int slot, rw;
        logic [7:0] mask;
        slot = n % RC;
        rw   = (n / RC) % rows;
        mask = 8'((1 << rows) - 1);
        if (slot >= BL) begin
            e_an[k] = mask & ~(8'(1 << rw));
            e_ca[k] = mbuf[k][mfront[k]][rw];
        end else begin
            e_an[k] = mask;
            e_ca[k] = 8'h00;
        end
        e_fs[k] = ((n % (RC * rows)) == 0);
        if (wr_en && int'(wr_row) < rows)
            mbuf[k][1 - mfront[k]][wr_row] = wr_data;
        e_ack[k] = (slot == RC - 1) && (rw == rows - 1) && (mpend[k] || swap_req);
        if (e_ack[k]) begin
            mfront[k] = 1 - mfront[k];
            mpend[k]  = 1'b0;
        end else if (swap_req) begin
            mpend[k] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            model_clear(0, 8);
            model_clear(1, 6);
        end else begin
            model_step(0, 8);
            model_step(1, 6);
            n++;
        end
    end

    always @(negedge clk) begin
        check("anode_r8", an8, e_an[0]);
        check("cathode_r8", ca8, e_ca[0]);
        check("frame_start_r8", {7'b0, fs8}, {7'b0, e_fs[0]});
        check("swap_ack_r8", {7'b0, ack8}, {7'b0, e_ack[0]});
        check("anode_r6", {2'b00, an6}, e_an[1]);
        check("cathode_r6", ca6, e_ca[1]);
        check("frame_start_r6", {7'b0, fs6}, {7'b0, e_fs[1]});
        check("swap_ack_r6", {7'b0, ack6}, {7'b0, e_ack[1]});
    end

    task automatic wait_an(input string name, input logic [7:0] v, input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (an8 === v) ok = 1'b1;
        end
        check(name, {7'b0, ok}, 8'h01);
    endtask

    initial begin : stim
        int acks, t1, t2, u1, u2, cyc;
        bit ok;

        // Reset held 5 cycles
        repeat (5) @(negedge clk);
        check("rst_anode", an8, 8'hFF);
        check("rst_cathode", ca8, 8'h00);
        check("rst_swap_ack", {7'b0, ack8}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("first_frame_start", {7'b0, fs8}, 8'h01);
        @(negedge clk);
        check("frame_start_single", {7'b0, fs8}, 8'h00);

        // Write back[3], request swap, run two frames
        wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hA5; swap_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; swap_req = 1'b0;
        acks = 0;
        repeat (160) begin
            @(negedge clk);
            if (ack8) acks++;
        end
        check("swap_once", 8'(acks), 8'd1);
        wait_an("reach_row3", 8'hF7, 100);
        check("row3_cathode", ca8, 8'hA5);

        // frame_start period
        t1 = -1; t2 = -1; u1 = -1; u2 = -1; cyc = 0;
        repeat (200) begin
            @(negedge clk);
            cyc++;
            if (fs8) begin if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc; end
            if (fs6) begin if (u1 < 0) u1 = cyc; else if (u2 < 0) u2 = cyc; end
        end
        check("fs_period_r8", 8'(t2 - t1), 8'd80);
        check("fs_period_r6", 8'(u2 - u1), 8'd60);

        // Repeated swap requests in one frame plus one on the wrap; write on the swap cycle
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (n % 80 == 0) ok = 1'b1;
            else @(negedge clk);
        end
        check("align_frame", {7'b0, ok}, 8'h01);
        acks = 0;
        repeat (100) begin
            int m;
            m = n % 80;
            swap_req = (m == 10 || m == 30 || m == 50 || m == 79);
            wr_en    = (m == 79);
            wr_row   = 3'd2;
            wr_data  = 8'h3C;
            @(negedge clk);
            if (ack8) acks++;
        end
        swap_req = 1'b0; wr_en = 1'b0;
        check("absorbed_swaps", 8'(acks), 8'd1);
        wait_an("reach_row2", 8'hFB, 100);
        check("swap_cycle_write", ca8, 8'h3C);

        // Write row 7 while it is displayed, plus an out-of-range row for the 6-row build
        wait_an("reach_row7", 8'h7F, 100);
        wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'h81;
        @(negedge clk);
        check("front_untouched_a", ca8, 8'h00);
        wr_row = 3'd6; wr_data = 8'h42;
        @(negedge clk);
        check("front_untouched_b", ca8, 8'h00);
        wr_en = 1'b0;
        @(negedge clk);
        check("front_untouched_c", ca8, 8'h00);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ack8) ok = 1'b1;
        end
        check("swap_seen", {7'b0, ok}, 8'h01);
        wait_an("reach_row6_new", 8'hBF, 100);
        check("row6_new", ca8, 8'h42);
        wait_an("reach_row7_new", 8'h7F, 100);
        check("row7_new", ca8, 8'h81);

        // Reset while row 5 drives
        wait_an("reach_row5", 8'hDF, 100);
        #1 rst = 1'b1;
        #1;
        check("midrst_anode", an8, 8'hFF);
        check("midrst_cathode", ca8, 8'h00);
        check("midrst_anode_r6", {2'b00, an6}, 8'h3F);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_an("reach_row3_after_rst", 8'hF7, 100);
        check("cleared_row3", ca8, 8'h00);
        wait_an("reach_row7_after_rst", 8'h7F, 100);
        check("cleared_row7", ca8, 8'h00);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
